// File: rtl/parity_tx.sv
// Parity encoder feeding a FIFO through a 2-entry skid buffer with registered grant.
// Optional PARITY_TX_INJECT_EN adds inject_i / inj_count_o for parity corruption.
module parity_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH:0]   data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
`ifdef PARITY_TX_INJECT_EN
  input  logic                  inject_i,
  output logic [CNT_WIDTH-1:0]  inj_count_o,
`endif
  output logic [CNT_WIDTH-1:0]  tx_count_o
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH:0]   main_q, main_d;
  logic [DATA_WIDTH:0]   skid_q, skid_d;
  logic                  grant_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  in_xfer, out_xfer;
  logic                  inj;
  logic                  par;
  logic [DATA_WIDTH:0]   enc;

`ifdef PARITY_TX_INJECT_EN
  assign inj = inject_i;
`else
  assign inj = 1'b0;
`endif

  assign par = (^data_i) ^ (EVEN_ODD != 0) ^ inj;
  assign enc = (PARITY_BIT == 0) ? {data_i, par} : {par, data_i};

  assign valid_o    = (state_q != EMPTY);
  assign grant_o    = grant_q;
  assign data_o     = main_q;
  assign tx_count_o = cnt_q;
  assign in_xfer    = valid_i & grant_q;
  assign out_xfer   = valid_o & grant_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = enc;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = enc;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = enc;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      grant_q <= (state_d != FULL);
      cnt_q   <= cnt_q + CNT_WIDTH'(out_xfer);
    end
  end

`ifdef PARITY_TX_INJECT_EN
  // Per-entry corruption flags travel alongside the stored words.
  logic                 main_inj_q, main_inj_d;
  logic                 skid_inj_q, skid_inj_d;
  logic [CNT_WIDTH-1:0] inj_cnt_q;

  always_comb begin
    main_inj_d = main_inj_q;
    skid_inj_d = skid_inj_q;
    if (main_d != main_q || state_d != state_q) begin
      if (state_q == FULL && out_xfer) begin
        main_inj_d = skid_inj_q;
      end else if (in_xfer && (state_q == EMPTY || out_xfer)) begin
        main_inj_d = inject_i;
      end
    end
    if (state_q == ONE && in_xfer && !out_xfer) begin
      skid_inj_d = inject_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_inj_q <= 1'b0;
      skid_inj_q <= 1'b0;
      inj_cnt_q  <= '0;
    end else begin
      main_inj_q <= main_inj_d;
      skid_inj_q <= skid_inj_d;
      inj_cnt_q  <= inj_cnt_q + CNT_WIDTH'(out_xfer & main_inj_q);
    end
  end

  assign inj_count_o = inj_cnt_q;
`endif

endmodule

// File: tb/tb_parity_tx.sv
// Directed self-checking bench for parity_tx: encoding variants, backpressure,
// streaming and mid-operation reset.
module tb_parity_tx;

  logic        clk;
  logic        rst;
  logic [31:0] data_i;
  logic        valid_i;
  logic        grant_i;
  logic        g0, g1, g2;
  logic        v0, v1, v2;
  logic [32:0] d0, d1, d2;
  logic [15:0] c0, c1, c2;
`ifdef PARITY_TX_INJECT_EN
  logic        inject_i;
  logic [15:0] ic0, ic1, ic2;
`endif

  int checks = 0;
  int errors = 0;

  parity_tx u0 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .grant_o(g0), .data_o(d0), .valid_o(v0), .grant_i(grant_i),
`ifdef PARITY_TX_INJECT_EN
    .inject_i(inject_i), .inj_count_o(ic0),
`endif
    .tx_count_o(c0)
  );

  parity_tx #(.EVEN_ODD(1)) u1 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .grant_o(g1), .data_o(d1), .valid_o(v1), .grant_i(grant_i),
`ifdef PARITY_TX_INJECT_EN
    .inject_i(inject_i), .inj_count_o(ic1),
`endif
    .tx_count_o(c1)
  );

  parity_tx #(.PARITY_BIT(1)) u2 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .grant_o(g2), .data_o(d2), .valid_o(v2), .grant_i(grant_i),
`ifdef PARITY_TX_INJECT_EN
    .inject_i(inject_i), .inj_count_o(ic2),
`endif
    .tx_count_o(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] enc_even(input logic [31:0] d);
    return {d, ^d};
  endfunction

  initial begin
    rst = 1'b1; data_i = '0; valid_i = 1'b0; grant_i = 1'b0;
`ifdef PARITY_TX_INJECT_EN
    inject_i = 1'b0;
`endif
    step(); step();
    chk("rst_valid", v0, 0);
    chk("rst_grant", g0, 0);
    chk("rst_count", c0, 0);
    chk("rst_data", d0, 0);
    rst = 1'b0;
    step();
    chk("grant_after_rel", g0, 1);

    // encoding
    grant_i = 1'b1; valid_i = 1'b1; data_i = 32'h3;
    step();
    chk("enc3_valid", v0, 1);
    chk("enc3_even", d0, 33'h006);
    chk("enc3_odd", d1, 33'h007);
    chk("enc3_pb1", d2, 33'h003);
    data_i = 32'h1;
    step();
    chk("enc1_even", d0, 33'h003);
    chk("enc1_odd", d1, 33'h002);
    chk("enc1_pb1", d2, 33'h100000001);
    valid_i = 1'b0;
    step();
    chk("drain_valid", v0, 0);
    chk("drain_count", c0, 2);
    grant_i = 1'b1;
    step();
    chk("empty_grant_nocount", c0, 2);

    // backpressure
    grant_i = 1'b0; valid_i = 1'b1; data_i = 32'hA;
    step();
    chk("bp_grant_one", g0, 1);
    data_i = 32'hB;
    step();
    chk("bp_grant_full", g0, 0);
    chk("bp_data_a", d0, 33'h014);
    data_i = 32'hC;
    step();
    chk("bp_hold_data", d0, 33'h014);
    chk("bp_hold_valid", v0, 1);
    chk("bp_hold_grant", g0, 0);
    chk("bp_hold_count", c0, 2);
    grant_i = 1'b1;
    step();
    chk("bp_out_b", d0, 33'h017);
    chk("bp_regrant", g0, 1);
    step();
    chk("bp_out_c", d0, 33'h018);
    valid_i = 1'b0;
    step();
    chk("bp_empty", v0, 0);
    chk("bp_count", c0, 5);

    // streaming
    valid_i = 1'b1; grant_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data_i = 32'(i) * 32'h01010101 + 32'h1;
      step();
      chk("st_valid", v0, 1);
      chk("st_grant", g0, 1);
      chk("st_data", d0, enc_even(32'(i) * 32'h01010101 + 32'h1));
    end
    valid_i = 1'b0;
    step();
    chk("st_count", c0, 105);

    // reset mid-operation from FULL
    grant_i = 1'b0; valid_i = 1'b1; data_i = 32'h55;
    step(); step();
    chk("mr_full", g0, 0);
    rst = 1'b1; grant_i = 1'b1;
    step();
    chk("mr_valid", v0, 0);
    chk("mr_count", c0, 0);
    chk("mr_grant", g0, 0);
    rst = 1'b0; valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_stale", v0, 0);
    end
    chk("mr_count_after", c0, 0);

`ifdef PARITY_TX_INJECT_EN
    valid_i = 1'b1; grant_i = 1'b1; data_i = 32'h3; inject_i = 1'b1;
    step();
    chk("inj_data", d0, 33'h007);
    inject_i = 1'b0;
    step();
    chk("inj_count", ic0, 1);
    chk("inj_clean", d0, 33'h006);
    valid_i = 1'b0;
    step();
    chk("inj_count_hold", ic0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
